// File: rtl/hazard_controller_pkg.sv
// Shared action encodings and scoreboard entry layout for the pipeline
// hazard controller and its per-stage trackers.
package hazard_controller_pkg;

  typedef enum logic [1:0] {
    ACTION_RUN    = 2'd0,
    ACTION_STALL  = 2'd1,
    ACTION_FREEZE = 2'd2,
    ACTION_FLUSH  = 2'd3
  } action_t;

  localparam int REG_IDX_W = 2;
  localparam int ENTRY_W   = 3 + REG_IDX_W;

  typedef struct packed {
    logic                 valid;
    logic                 reg_write;
    logic                 mem_read;
    logic [REG_IDX_W-1:0] dest;
  } entry_t;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/hazard_controller_stage_tracker.sv
// One scoreboard entry: shadows the destination of the instruction in a
// single pipeline stage. hold beats clear, clear beats load.
module stage_tracker
  import hazard_controller_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   load,
  input  logic   clear,
  input  logic   hold,
  input  entry_t d,
  output entry_t q
);

  logic                 valid;
  logic                 reg_write;
  logic                 mem_read;
  logic [REG_IDX_W-1:0] dest;

  // Only the valid bit needs reset; the payload is ignored while invalid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
    end else if (!hold) begin
      if (clear) begin
        valid <= 1'b0;
      end else if (load) begin
        valid <= d.valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!hold && !clear && load) begin
      reg_write <= d.reg_write;
      mem_read  <= d.mem_read;
      dest      <= d.dest;
    end
  end

  assign q = '{valid: valid, reg_write: reg_write, mem_read: mem_read, dest: dest};

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: tracks EX/MEM/WB destinations and picks
// RUN, STALL, FREEZE or FLUSH each cycle, with saturating perf counters.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter logic DATA_FORWARDING = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  rs_id,
  input  logic [1:0]  rt_id,
  input  logic        rs_used_id,
  input  logic        rt_used_id,
  input  logic        reg_write_id,
  input  logic [1:0]  write_reg_id,
  input  logic        mem_read_id,
  input  logic        branch_taken_ex,
  input  logic        mem_busy,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        pipe_hold,
  output logic [1:0]  last_action,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);

  entry_t  ex_e, mem_e, wb_e, id_e;
  action_t action, last_q;
  logic    fwd_hazard, any_hazard, hazard;

  function automatic logic hit(input entry_t e, input logic used,
                               input logic [REG_IDX_W-1:0] idx);
    return e.valid & e.reg_write & used & (idx == e.dest);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == CNT_MAX) ? c : c + 16'd1;
  endfunction

  assign fwd_hazard = ex_e.mem_read &
                      (hit(ex_e, rs_used_id, rs_id) | hit(ex_e, rt_used_id, rt_id));
  // Without write-through in the register file, a WB producer still blocks.
  assign any_hazard = hit(ex_e,  rs_used_id, rs_id) | hit(ex_e,  rt_used_id, rt_id) |
                      hit(mem_e, rs_used_id, rs_id) | hit(mem_e, rt_used_id, rt_id) |
                      hit(wb_e,  rs_used_id, rs_id) | hit(wb_e,  rt_used_id, rt_id);
  assign hazard = DATA_FORWARDING ? fwd_hazard : any_hazard;

  always_comb begin
    action = ACTION_RUN;
    if (mem_busy)             action = ACTION_FREEZE;
    else if (branch_taken_ex) action = ACTION_FLUSH;
    else if (hazard)          action = ACTION_STALL;
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    case (action)
      ACTION_STALL: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
      ACTION_FREEZE: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        pipe_hold  = 1'b1;
      end
      ACTION_FLUSH: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      default: ;
    endcase
    if (!reset_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      pipe_hold   = 1'b0;
    end
  end

  assign id_e = '{valid: 1'b1, reg_write: reg_write_id, mem_read: mem_read_id,
                  dest: write_reg_id};

  // Scoreboard shift: ID -> EX -> MEM -> WB, WB discarded on every advance.
  stage_tracker u_ex (
    .clk(clk), .reset_n(reset_n), .load(action == ACTION_RUN),
    .clear((action == ACTION_STALL) || (action == ACTION_FLUSH)),
    .hold(action == ACTION_FREEZE), .d(id_e), .q(ex_e)
  );
  stage_tracker u_mem (
    .clk(clk), .reset_n(reset_n), .load(1'b1), .clear(1'b0),
    .hold(action == ACTION_FREEZE), .d(ex_e), .q(mem_e)
  );
  stage_tracker u_wb (
    .clk(clk), .reset_n(reset_n), .load(1'b1), .clear(1'b0),
    .hold(action == ACTION_FREEZE), .d(mem_e), .q(wb_e)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q       <= ACTION_RUN;
      stall_cycles <= 16'd0;
      flush_count  <= 16'd0;
    end else begin
      last_q <= action;
      if ((action == ACTION_STALL) || (action == ACTION_FREEZE))
        stall_cycles <= sat_inc(stall_cycles);
      if (action == ACTION_FLUSH)
        flush_count <= sat_inc(flush_count);
    end
  end

  assign last_action = last_q;

endmodule
